// File: rtl/proc_pkg.sv
// Shared types and constants for the processor core pipeline stages.
package proc_pkg;

  // ALU operations understood by the execute stage.
  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_t;

  // RV32I major opcodes (instruction bits [6:0]).
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [31:0] INSTR_NOP  = 32'h0000_0013;
  localparam logic [31:0] INSTR_HALT = 32'h0010_0073;

  // Contents of the ID/EX pipeline register.
  typedef struct packed {
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [31:0] pc_curr;
    logic [31:0] pc_next;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    alu_op_t     alu_op;
    logic        alu_src;
    logic        alu_a_pc;
    logic        memrd;
    logic        memwr;
    logic        regwr;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic        illegal;
  } idex_t;

  // A bubble does nothing: no controls, zero data, PCs parked at pc.
  function automatic idex_t make_bubble(input logic [31:0] pc);
    idex_t b;
    b         = '0;
    b.alu_op  = ALU_ADD;
    b.pc_curr = pc;
    b.pc_next = pc;
    return b;
  endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 register file: two write-first read ports, one write port, x0 hardwired to zero.
module regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] regs_reg [32];
  logic [4:0]  ra    [2];
  logic [31:0] rdata [2];

  assign ra[0] = ra1;
  assign ra[1] = ra2;
  assign rd1   = rdata[0];
  assign rd2   = rdata[1];

  // Storage update: reset clears everything, writes to x0 are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (we && (wa != 5'd0)) begin
      regs_reg[wa] <= wd;
    end
  end

  // Identical read logic per port; a same-cycle write bypasses storage.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_read
      // Read port gi: x0 is zero, then writeback bypass, then storage.
      always_comb begin
        rdata[gi] = regs_reg[ra[gi]];
        if (ra[gi] == 5'd0) begin
          rdata[gi] = '0;
        end else if (we && (wa == ra[gi])) begin
          rdata[gi] = wd;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/decode_stage.sv
// Decode stage: RV32I decode, immediate build, register read, load-use
// detection and the ID/EX pipeline register feeding execute.
module decode_stage
  import proc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction_dec,
  input  logic [31:0] pc_curr_dec,
  input  logic [31:0] pc_next_dec,
  input  logic        flush,
  input  logic        stall_mem,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        hazard,
  output logic        halt,
  output logic [31:0] rs1_data_ex,
  output logic [31:0] rs2_data_ex,
  output logic [31:0] imm_ex,
  output logic [31:0] pc_curr_ex,
  output logic [31:0] pc_next_ex,
  output logic [4:0]  rs1_ex,
  output logic [4:0]  rs2_ex,
  output logic [4:0]  rd_ex,
  output logic [2:0]  funct3_ex,
  output alu_op_t     alu_op_ex,
  output logic        alu_src_ex,
  output logic        alu_a_pc_ex,
  output logic        memrd_ex,
  output logic        memwr_ex,
  output logic        regwr_ex,
  output logic        branch_ex,
  output logic        jal_ex,
  output logic        jalr_ex,
  output logic        illegal_ex
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_b5;
  logic        use_rs1;
  logic        use_rs2;
  logic [4:0]  rs1_idx;
  logic [4:0]  rs2_idx;
  logic [31:0] rf_rd1;
  logic [31:0] rf_rd2;
  logic        is_halt;
  idex_t       dec;
  idex_t       idex_reg;
  logic        halt_reg;

  assign opcode    = instruction_dec[6:0];
  assign funct3    = instruction_dec[14:12];
  assign funct7_b5 = instruction_dec[30];
  assign is_halt   = (instruction_dec == INSTR_HALT);

  // Which source registers the instruction actually reads; unused indices
  // are zeroed so neither the hazard check nor forwarding sees stray fields.
  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    unique case (opcode)
      OPC_JALR, OPC_LOAD, OPC_OP_IMM: use_rs1 = 1'b1;
      OPC_BRANCH, OPC_STORE, OPC_OP: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      default: ;
    endcase
    rs1_idx = use_rs1 ? instruction_dec[19:15] : 5'd0;
    rs2_idx = use_rs2 ? instruction_dec[24:20] : 5'd0;
  end

  regfile u_regfile (
    .clk (clk),
    .rst (rst),
    .ra1 (rs1_idx),
    .ra2 (rs2_idx),
    .we  (wb_en),
    .wa  (wb_rd),
    .wd  (wb_data),
    .rd1 (rf_rd1),
    .rd2 (rf_rd2)
  );

  // Full decode of the presented instruction into an ID/EX record.
  always_comb begin
    dec          = make_bubble(pc_curr_dec);
    dec.pc_curr  = pc_curr_dec;
    dec.pc_next  = pc_next_dec;
    dec.rs1      = rs1_idx;
    dec.rs2      = rs2_idx;
    dec.rs1_data = rf_rd1;
    dec.rs2_data = rf_rd2;
    unique case (opcode)
      OPC_LUI: begin
        dec.imm     = {instruction_dec[31:12], 12'b0};
        dec.alu_op  = ALU_PASSB;
        dec.alu_src = 1'b1;
        dec.regwr   = 1'b1;
      end
      OPC_AUIPC: begin
        dec.imm      = {instruction_dec[31:12], 12'b0};
        dec.alu_src  = 1'b1;
        dec.alu_a_pc = 1'b1;
        dec.regwr    = 1'b1;
      end
      OPC_JAL: begin
        dec.imm      = {{11{instruction_dec[31]}}, instruction_dec[31],
                        instruction_dec[19:12], instruction_dec[20],
                        instruction_dec[30:21], 1'b0};
        dec.alu_src  = 1'b1;
        dec.alu_a_pc = 1'b1;
        dec.regwr    = 1'b1;
        dec.jal      = 1'b1;
      end
      OPC_JALR: begin
        dec.imm     = {{20{instruction_dec[31]}}, instruction_dec[31:20]};
        dec.funct3  = funct3;
        dec.alu_src = 1'b1;
        dec.regwr   = 1'b1;
        dec.jalr    = 1'b1;
      end
      OPC_BRANCH: begin
        // Comparison is chosen by funct3 in execute; the ALU op is unused.
        dec.imm    = {{19{instruction_dec[31]}}, instruction_dec[31],
                      instruction_dec[7], instruction_dec[30:25],
                      instruction_dec[11:8], 1'b0};
        dec.funct3 = funct3;
        dec.branch = 1'b1;
      end
      OPC_LOAD: begin
        dec.imm     = {{20{instruction_dec[31]}}, instruction_dec[31:20]};
        dec.funct3  = funct3;
        dec.alu_src = 1'b1;
        dec.memrd   = 1'b1;
        dec.regwr   = 1'b1;
      end
      OPC_STORE: begin
        dec.imm     = {{20{instruction_dec[31]}}, instruction_dec[31:25],
                       instruction_dec[11:7]};
        dec.funct3  = funct3;
        dec.alu_src = 1'b1;
        dec.memwr   = 1'b1;
      end
      OPC_OP_IMM, OPC_OP: begin
        dec.funct3 = funct3;
        dec.regwr  = 1'b1;
        if (opcode == OPC_OP_IMM) begin
          dec.imm     = {{20{instruction_dec[31]}}, instruction_dec[31:20]};
          dec.alu_src = 1'b1;
        end
        unique case (funct3)
          3'b000:  dec.alu_op = (opcode == OPC_OP && funct7_b5) ? ALU_SUB : ALU_ADD;
          3'b001:  dec.alu_op = ALU_SLL;
          3'b010:  dec.alu_op = ALU_SLT;
          3'b011:  dec.alu_op = ALU_SLTU;
          3'b100:  dec.alu_op = ALU_XOR;
          3'b101:  dec.alu_op = funct7_b5 ? ALU_SRA : ALU_SRL;
          3'b110:  dec.alu_op = ALU_OR;
          default: dec.alu_op = ALU_AND;
        endcase
      end
      default: begin
        // Unknown opcode: a NOP flagged illegal, no operands carried.
        dec.rs1      = '0;
        dec.rs2      = '0;
        dec.rs1_data = '0;
        dec.rs2_data = '0;
        dec.illegal  = 1'b1;
      end
    endcase
    if (dec.regwr) begin
      dec.rd = instruction_dec[11:7];
    end
  end

  // Load-use: the load in ID/EX produces a register this instruction reads.
  always_comb begin
    hazard = idex_reg.memrd && (idex_reg.rd != 5'd0) &&
             ((use_rs1 && (idex_reg.rd == rs1_idx)) ||
              (use_rs2 && (idex_reg.rd == rs2_idx)));
  end

  // ID/EX register and sticky halt, in priority order.
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_reg <= make_bubble(RESET_PC);
      halt_reg <= 1'b0;
    end else if (flush) begin
      idex_reg <= make_bubble(RESET_PC);
    end else if (stall_mem) begin
      idex_reg <= idex_reg;
    end else if (hazard) begin
      idex_reg <= make_bubble(RESET_PC);
    end else if (is_halt) begin
      idex_reg <= make_bubble(RESET_PC);
      halt_reg <= 1'b1;
    end else begin
      idex_reg <= dec;
    end
  end

  assign halt        = halt_reg;
  assign rs1_data_ex = idex_reg.rs1_data;
  assign rs2_data_ex = idex_reg.rs2_data;
  assign imm_ex      = idex_reg.imm;
  assign pc_curr_ex  = idex_reg.pc_curr;
  assign pc_next_ex  = idex_reg.pc_next;
  assign rs1_ex      = idex_reg.rs1;
  assign rs2_ex      = idex_reg.rs2;
  assign rd_ex       = idex_reg.rd;
  assign funct3_ex   = idex_reg.funct3;
  assign alu_op_ex   = idex_reg.alu_op;
  assign alu_src_ex  = idex_reg.alu_src;
  assign alu_a_pc_ex = idex_reg.alu_a_pc;
  assign memrd_ex    = idex_reg.memrd;
  assign memwr_ex    = idex_reg.memwr;
  assign regwr_ex    = idex_reg.regwr;
  assign branch_ex   = idex_reg.branch;
  assign jal_ex      = idex_reg.jal;
  assign jalr_ex     = idex_reg.jalr;
  assign illegal_ex  = idex_reg.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage with hand-computed expectations.
module tb_decode_stage;
  import proc_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instruction_dec = INSTR_NOP;
  logic [31:0] pc_curr_dec = '0;
  logic [31:0] pc_next_dec = '0;
  logic        flush = 1'b0;
  logic        stall_mem = 1'b0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        hazard, halt;
  logic [31:0] rs1_data_ex, rs2_data_ex, imm_ex, pc_curr_ex, pc_next_ex;
  logic [4:0]  rs1_ex, rs2_ex, rd_ex;
  logic [2:0]  funct3_ex;
  alu_op_t     alu_op_ex;
  logic        alu_src_ex, alu_a_pc_ex, memrd_ex, memwr_ex, regwr_ex;
  logic        branch_ex, jal_ex, jalr_ex, illegal_ex;

  int checks = 0;
  int failures = 0;

  decode_stage #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .instruction_dec(instruction_dec),
    .pc_curr_dec(pc_curr_dec), .pc_next_dec(pc_next_dec),
    .flush(flush), .stall_mem(stall_mem),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .hazard(hazard), .halt(halt),
    .rs1_data_ex(rs1_data_ex), .rs2_data_ex(rs2_data_ex), .imm_ex(imm_ex),
    .pc_curr_ex(pc_curr_ex), .pc_next_ex(pc_next_ex),
    .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex), .funct3_ex(funct3_ex),
    .alu_op_ex(alu_op_ex), .alu_src_ex(alu_src_ex), .alu_a_pc_ex(alu_a_pc_ex),
    .memrd_ex(memrd_ex), .memwr_ex(memwr_ex), .regwr_ex(regwr_ex),
    .branch_ex(branch_ex), .jal_ex(jal_ex), .jalr_ex(jalr_ex),
    .illegal_ex(illegal_ex)
  );

  always #5 clk = ~clk;

  // Present an instruction and its PC pair to the stage.
  task automatic present(input logic [31:0] instr, input logic [31:0] pc);
    instruction_dec = instr;
    pc_curr_dec     = pc;
    pc_next_dec     = pc + 32'd4;
    $display("txn instr=%h pc=%h flush=%0b stall=%0b wb_en=%0b rst=%0b",
             instr, pc, flush, stall_mem, wb_en, rst);
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    present(INSTR_NOP, 32'h100);
    step();
    step();
    checks++;
    if ({rs1_data_ex, rs2_data_ex, imm_ex, pc_curr_ex, pc_next_ex} !== 160'd0) begin
      failures++; $display("FAIL reset_data got %h %h %h %h %h want 0", rs1_data_ex, rs2_data_ex, imm_ex, pc_curr_ex, pc_next_ex);
    end
    checks++;
    if ({rs1_ex, rs2_ex, rd_ex, funct3_ex} !== 18'd0) begin
      failures++; $display("FAIL reset_idx got %h %h %h %h want 0", rs1_ex, rs2_ex, rd_ex, funct3_ex);
    end
    checks++;
    if ({alu_src_ex, alu_a_pc_ex, memrd_ex, memwr_ex, regwr_ex, branch_ex, jal_ex, jalr_ex, illegal_ex} !== 9'd0) begin
      failures++; $display("FAIL reset_ctrl got nonzero controls");
    end
    checks++;
    if (alu_op_ex !== ALU_ADD || hazard !== 1'b0 || halt !== 1'b0) begin
      failures++; $display("FAIL reset_misc got alu=%0d hazard=%b halt=%b want 0 0 0", alu_op_ex, hazard, halt);
    end
    rst = 1'b0;
  endtask

  task automatic test_itype();
    present(32'h0050_0093, 32'h10);
    step();
    checks++;
    if (rd_ex !== 5'd1 || imm_ex !== 32'd5 || alu_src_ex !== 1'b1 || regwr_ex !== 1'b1) begin
      failures++; $display("FAIL itype_decode got rd=%0d imm=%h src=%b regwr=%b want 1 5 1 1", rd_ex, imm_ex, alu_src_ex, regwr_ex);
    end
    checks++;
    if (pc_curr_ex !== 32'h10 || pc_next_ex !== 32'h14 || alu_op_ex !== ALU_ADD) begin
      failures++; $display("FAIL itype_pc got pc=%h next=%h alu=%0d want 10 14 0", pc_curr_ex, pc_next_ex, alu_op_ex);
    end
  endtask

  task automatic test_btype();
    present(32'hFE00_0EE3, 32'h20);
    step();
    checks++;
    if (imm_ex !== 32'hFFFF_FFFC || branch_ex !== 1'b1 || regwr_ex !== 1'b0 || rd_ex !== 5'd0 || alu_src_ex !== 1'b0) begin
      failures++; $display("FAIL btype got imm=%h br=%b regwr=%b rd=%0d src=%b want fffffffc 1 0 0 0", imm_ex, branch_ex, regwr_ex, rd_ex, alu_src_ex);
    end
  endtask

  task automatic test_bypass();
    wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'hDEAD_BEEF;
    present(32'h0010_8133, 32'h24);
    step();
    checks++;
    if (rs1_data_ex !== 32'hDEAD_BEEF || rs2_data_ex !== 32'hDEAD_BEEF || rd_ex !== 5'd2) begin
      failures++; $display("FAIL bypass got rs1=%h rs2=%h rd=%0d want deadbeef deadbeef 2", rs1_data_ex, rs2_data_ex, rd_ex);
    end
    // Value must have landed in storage too, and x0 must ignore writes.
    wb_rd = 5'd0; wb_data = 32'h0000_1234;
    present(32'h0010_8133, 32'h28);
    step();
    checks++;
    if (rs1_data_ex !== 32'hDEAD_BEEF || rs1_ex !== 5'd1 || rs2_ex !== 5'd1) begin
      failures++; $display("FAIL stored_read got %h rs1=%0d rs2=%0d want deadbeef 1 1", rs1_data_ex, rs1_ex, rs2_ex);
    end
    wb_en = 1'b0;
    present(32'h0000_0133, 32'h2C);
    step();
    checks++;
    if (rs1_data_ex !== 32'd0 || rs2_data_ex !== 32'd0) begin
      failures++; $display("FAIL x0_read got %h %h want 0 0", rs1_data_ex, rs2_data_ex);
    end
  endtask

  task automatic test_alu_ops();
    present(32'h4020_81B3, 32'h30);  // sub x3,x1,x2
    step();
    checks++;
    if (alu_op_ex !== ALU_SUB || rd_ex !== 5'd3 || imm_ex !== 32'd0) begin
      failures++; $display("FAIL sub got alu=%0d rd=%0d imm=%h want 1 3 0", alu_op_ex, rd_ex, imm_ex);
    end
    present(32'h4030_D213, 32'h34);  // srai x4,x1,3
    step();
    checks++;
    if (alu_op_ex !== ALU_SRA || funct3_ex !== 3'b101 || rd_ex !== 5'd4) begin
      failures++; $display("FAIL srai got alu=%0d f3=%0d rd=%0d want 7 5 4", alu_op_ex, funct3_ex, rd_ex);
    end
    present(32'h4000_0093, 32'h38);  // addi x1,x0,0x400 : bit30 set, still ADD
    step();
    checks++;
    if (alu_op_ex !== ALU_ADD || imm_ex !== 32'h400) begin
      failures++; $display("FAIL addi_b30 got alu=%0d imm=%h want 0 400", alu_op_ex, imm_ex);
    end
    present(32'h1234_52B7, 32'h3C);  // lui x5,0x12345
    step();
    checks++;
    if (alu_op_ex !== ALU_PASSB || imm_ex !== 32'h1234_5000 || rd_ex !== 5'd5 || alu_src_ex !== 1'b1) begin
      failures++; $display("FAIL lui got alu=%0d imm=%h rd=%0d src=%b want 10 12345000 5 1", alu_op_ex, imm_ex, rd_ex, alu_src_ex);
    end
    present(32'h0000_007F, 32'h40);  // unknown opcode
    step();
    checks++;
    if (illegal_ex !== 1'b1 || regwr_ex !== 1'b0 || memrd_ex !== 1'b0 || memwr_ex !== 1'b0) begin
      failures++; $display("FAIL illegal got ill=%b regwr=%b rd=%b wr=%b want 1 0 0 0", illegal_ex, regwr_ex, memrd_ex, memwr_ex);
    end
  endtask

  task automatic test_load_use();
    present(32'h0000_2283, 32'h50);  // lw x5,0(x0)
    step();
    checks++;
    if (memrd_ex !== 1'b1 || rd_ex !== 5'd5) begin
      failures++; $display("FAIL lw_decode got memrd=%b rd=%0d want 1 5", memrd_ex, rd_ex);
    end
    present(32'h0002_8333, 32'h54);  // add x6,x5,x0
    #1;
    checks++;
    if (hazard !== 1'b1) begin
      failures++; $display("FAIL hazard_set got %b want 1", hazard);
    end
    step();
    checks++;
    if (regwr_ex !== 1'b0 || memrd_ex !== 1'b0 || rd_ex !== 5'd0 || pc_curr_ex !== 32'd0 || hazard !== 1'b0) begin
      failures++; $display("FAIL hazard_bubble got regwr=%b memrd=%b rd=%0d pc=%h hz=%b want 0 0 0 0 0", regwr_ex, memrd_ex, rd_ex, pc_curr_ex, hazard);
    end
    step();
    checks++;
    if (rd_ex !== 5'd6 || rs1_ex !== 5'd5 || regwr_ex !== 1'b1 || pc_curr_ex !== 32'h54) begin
      failures++; $display("FAIL hazard_replay got rd=%0d rs1=%0d regwr=%b pc=%h want 6 5 1 54", rd_ex, rs1_ex, regwr_ex, pc_curr_ex);
    end
  endtask

  task automatic test_control();
    present(32'h0050_0093, 32'h60);
    step();
    stall_mem = 1'b1;
    present(32'h1234_52B7, 32'h64);
    step();
    checks++;
    if (rd_ex !== 5'd1 || imm_ex !== 32'd5 || pc_curr_ex !== 32'h60 || alu_op_ex !== ALU_ADD) begin
      failures++; $display("FAIL stall_hold got rd=%0d imm=%h pc=%h alu=%0d want 1 5 60 0", rd_ex, imm_ex, pc_curr_ex, alu_op_ex);
    end
    // Stall together with a load-use hazard: hold, hazard still driven.
    stall_mem = 1'b0;
    present(32'h0000_2283, 32'h68);
    step();
    stall_mem = 1'b1;
    present(32'h0002_8333, 32'h6C);
    step();
    checks++;
    if (memrd_ex !== 1'b1 || rd_ex !== 5'd5 || hazard !== 1'b1) begin
      failures++; $display("FAIL stall_hazard got memrd=%b rd=%0d hz=%b want 1 5 1", memrd_ex, rd_ex, hazard);
    end
    flush = 1'b1;
    step();
    checks++;
    if (regwr_ex !== 1'b0 || memrd_ex !== 1'b0 || rd_ex !== 5'd0 || pc_curr_ex !== 32'd0) begin
      failures++; $display("FAIL flush_stall got regwr=%b memrd=%b rd=%0d pc=%h want bubble", regwr_ex, memrd_ex, rd_ex, pc_curr_ex);
    end
    stall_mem = 1'b0;
    present(INSTR_HALT, 32'h70);
    step();
    checks++;
    if (halt !== 1'b0) begin
      failures++; $display("FAIL flush_halt got halt=%b want 0", halt);
    end
    flush = 1'b0;
    step();
    checks++;
    if (halt !== 1'b1 || regwr_ex !== 1'b0 || illegal_ex !== 1'b0 || pc_curr_ex !== 32'd0) begin
      failures++; $display("FAIL halt_set got halt=%b regwr=%b ill=%b pc=%h want 1 0 0 0", halt, regwr_ex, illegal_ex, pc_curr_ex);
    end
    for (int i = 0; i < 10; i++) begin
      present(32'h0050_0093, 32'h74 + 32'(i * 4));
      step();
      checks++;
      if (halt !== 1'b1) begin
        failures++; $display("FAIL halt_sticky cycle=%0d got %b want 1", i, halt);
      end
    end
    checks++;
    if (regwr_ex !== 1'b1 || rd_ex !== 5'd1) begin
      failures++; $display("FAIL after_halt got regwr=%b rd=%0d want 1 1", regwr_ex, rd_ex);
    end
    // Reset during a stall wins and clears halt.
    stall_mem = 1'b1;
    rst = 1'b1;
    step();
    checks++;
    if (halt !== 1'b0 || regwr_ex !== 1'b0 || rd_ex !== 5'd0 || pc_curr_ex !== 32'd0) begin
      failures++; $display("FAIL rst_stall got halt=%b regwr=%b rd=%0d pc=%h want 0 0 0 0", halt, regwr_ex, rd_ex, pc_curr_ex);
    end
    rst = 1'b0;
    stall_mem = 1'b0;
    // Reset also cleared x1 written earlier.
    present(32'h0010_8133, 32'h90);
    step();
    checks++;
    if (rs1_data_ex !== 32'd0 || rd_ex !== 5'd2) begin
      failures++; $display("FAIL rst_regfile got rs1=%h rd=%0d want 0 2", rs1_data_ex, rd_ex);
    end
  endtask

  initial begin
    test_reset();
    test_itype();
    test_btype();
    test_bypass();
    test_alu_ops();
    test_load_use();
    test_control();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
